// File: rtl/memn2n_story_tx.sv
// memn2n_story_tx
// Story transmitter for the MemN2N core. Host words arrive over a valid/ready
// handshake and are buffered in a small FIFO. They are then presented one at
// a time on data_in as {type, word} with a one-cycle en strobe. After a
// sentence or question word the block waits for done_emb, or gives up after
// TIMEOUT cycles. Sentence words are counted against memory capacity.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   s_valid/s_ready   host handshake; s_word, s_type, s_last are the payload
//   data_in           {type, word} presented to the core, held between words
//   en                one-cycle issue strobe
//   we_sen/we_query   qualifiers, high only in the issue cycle of that type
//   done_emb          embedding-complete pulse from the core
//   story_done        one-cycle pulse when the last word of a story completes
//   sen_count         sentence words issued in the current story (saturating)
//   err_overflow      sticky, a sentence word was dropped (memory full)
//   err_timeout       sticky, done_emb never arrived within TIMEOUT cycles
module memn2n_story_tx #(
  parameter int BW_WORD_VEC   = 8,
  parameter int BW_TYPE_CODE  = 2,
  parameter int BW_DATA_IN    = BW_WORD_VEC + BW_TYPE_CODE,
  parameter int BW_MEM_ADDR   = 4,
  parameter int BW_FIFO_DEPTH = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [BW_WORD_VEC-1:0]  s_word,
  input  logic [BW_TYPE_CODE-1:0] s_type,
  input  logic                    s_last,
  output logic [BW_DATA_IN-1:0]   data_in,
  output logic                    en,
  output logic                    we_sen,
  output logic                    we_query,
  input  logic                    done_emb,
  output logic                    story_done,
  output logic [BW_MEM_ADDR:0]    sen_count,
  output logic                    err_overflow,
  output logic                    err_timeout
);

  localparam int DEPTH   = 1 << BW_FIFO_DEPTH;
  localparam int ENTRY_W = 1 + BW_TYPE_CODE + BW_WORD_VEC;
  localparam int WAIT_W  = $clog2(TIMEOUT) + 1;

  localparam logic [BW_TYPE_CODE-1:0] TYPE_NONE = BW_TYPE_CODE'(0);
  localparam logic [BW_TYPE_CODE-1:0] TYPE_SEN  = BW_TYPE_CODE'(1);
  localparam logic [BW_TYPE_CODE-1:0] TYPE_ANS  = BW_TYPE_CODE'(3);
  localparam logic [BW_TYPE_CODE-1:0] TYPE_QRY  = BW_TYPE_CODE'(2);

  localparam logic [BW_MEM_ADDR:0] MEM_FULL  = {1'b1, {BW_MEM_ADDR{1'b0}}};
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t state_q, state_d;

  logic [ENTRY_W-1:0]       fifoMem_q [DEPTH];
  logic [BW_FIFO_DEPTH:0]   wrPtr_q, rdPtr_q;
  logic                     fifoEmpty, fifoFull, push, pop;
  logic [ENTRY_W-1:0]       head;
  logic                     headLast;
  logic [BW_TYPE_CODE-1:0]  headType;
  logic [BW_WORD_VEC-1:0]   headWord;

  // Only the last flag and type of the popped word are needed after the pop;
  // the full {type, word} lives in dataIn_q.
  logic                     holdLast_q, holdLast_d;
  logic [BW_TYPE_CODE-1:0]  holdType_q, holdType_d;
  logic [BW_DATA_IN-1:0]    dataIn_q, dataIn_d;
  logic [WAIT_W-1:0]        waitCnt_q, waitCnt_d;
  logic [BW_MEM_ADDR:0]     senCount_q, senCount_d;
  logic                     dropDone_q, dropDone_d;
  logic                     errOverflow_q, errOverflow_d;
  logic                     errTimeout_q, errTimeout_d;

  // FIFO status: the extra MSB of each pointer tells full apart from empty.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[BW_FIFO_DEPTH] != rdPtr_q[BW_FIFO_DEPTH]) &&
                     (wrPtr_q[BW_FIFO_DEPTH-1:0] == rdPtr_q[BW_FIFO_DEPTH-1:0]);

  assign s_ready = !fifoFull && !rst;
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == IDLE) && !fifoEmpty;

  assign head     = fifoMem_q[rdPtr_q[BW_FIFO_DEPTH-1:0]];
  assign headLast = head[ENTRY_W-1];
  assign headType = head[ENTRY_W-2 -: BW_TYPE_CODE];
  assign headWord = head[BW_WORD_VEC-1:0];

  // Issue strobes come straight from the registered state so they last
  // exactly the one ISSUE cycle; story_done covers both the GAP path and the
  // delayed pulse for a discarded last word.
  assign en         = (state_q == ISSUE) && !rst;
  assign we_sen     = en && (holdType_q == TYPE_SEN);
  assign we_query   = en && (holdType_q == TYPE_QRY);
  assign story_done = !rst && (((state_q == GAP) && holdLast_q) || dropDone_q);

  assign data_in      = dataIn_q;
  assign sen_count    = senCount_q;
  assign err_overflow = errOverflow_q;
  assign err_timeout  = errTimeout_q;

  // FIFO storage has no reset; stale entries are never read because the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q[BW_FIFO_DEPTH-1:0]] <= {s_last, s_type, s_word};
    end
  end

  // Next-state logic. A popped word that is type 00, or a sentence arriving
  // with memory already full, is consumed in IDLE without being issued.
  always_comb begin
    state_d       = state_q;
    holdLast_d    = holdLast_q;
    holdType_d    = holdType_q;
    dataIn_d      = dataIn_q;
    waitCnt_d     = waitCnt_q;
    senCount_d    = senCount_q;
    dropDone_d    = 1'b0;
    errOverflow_d = errOverflow_q;
    errTimeout_d  = errTimeout_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          holdLast_d = headLast;
          holdType_d = headType;
          if (headType == TYPE_NONE) begin
            dropDone_d = headLast;
          end else if ((headType == TYPE_SEN) && (senCount_q == MEM_FULL)) begin
            errOverflow_d = 1'b1;
            dropDone_d    = headLast;
          end else begin
            dataIn_d = {headType, headWord};
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        // done_emb in this cycle is deliberately not looked at.
        waitCnt_d = '0;
        if ((holdType_q == TYPE_SEN) && (senCount_q != MEM_FULL)) begin
          senCount_d = senCount_q + 1'b1;
        end
        state_d = (holdType_q == TYPE_ANS) ? GAP : WAIT;
      end
      WAIT: begin
        if (done_emb) begin
          state_d = GAP;
        end else if (waitCnt_q == WAIT_LAST) begin
          errTimeout_d = 1'b1;
          state_d      = GAP;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ending a story clears the sentence count one cycle after the pulse.
    if (story_done) begin
      senCount_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      holdLast_q    <= 1'b0;
      holdType_q    <= '0;
      dataIn_q      <= '0;
      waitCnt_q     <= '0;
      senCount_q    <= '0;
      dropDone_q    <= 1'b0;
      errOverflow_q <= 1'b0;
      errTimeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      holdLast_q    <= holdLast_d;
      holdType_q    <= holdType_d;
      dataIn_q      <= dataIn_d;
      waitCnt_q     <= waitCnt_d;
      senCount_q    <= senCount_d;
      dropDone_q    <= dropDone_d;
      errOverflow_q <= errOverflow_d;
      errTimeout_q  <= errTimeout_d;
    end
  end

endmodule

// File: tb/tb_memn2n_story_tx.sv
// tb_memn2n_story_tx
// Directed bench for memn2n_story_tx. Inputs are driven and outputs sampled
// on the falling clock edge. A responder returns done_emb a programmable
// number of cycles after each en; a monitor logs every issued data_in.
module tb_memn2n_story_tx;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_SEN  = 2'b01;
  localparam logic [1:0] T_QRY  = 2'b10;
  localparam logic [1:0] T_ANS  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_word;
  logic [1:0] s_type;
  logic       s_last;
  logic [9:0] data_in;
  logic       en;
  logic       we_sen;
  logic       we_query;
  logic       done_emb;
  logic       story_done;
  logic [4:0] sen_count;
  logic       err_overflow;
  logic       err_timeout;

  logic       doneAuto  = 1'b0;
  logic       doneForce = 1'b0;
  int         doneDelay = 0;
  int         pending   = 0;
  int         cycleNo   = 0;
  logic [9:0] issuedQ [$];
  int         enCycleQ [$];

  int assertCount = 0;
  int failCount   = 0;

  assign done_emb = doneAuto | doneForce;

  memn2n_story_tx dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_word       (s_word),
    .s_type       (s_type),
    .s_last       (s_last),
    .data_in      (data_in),
    .en           (en),
    .we_sen       (we_sen),
    .we_query     (we_query),
    .done_emb     (done_emb),
    .story_done   (story_done),
    .sen_count    (sen_count),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo = cycleNo + 1;

  // Embedding responder: pulse done_emb doneDelay cycles after each en.
  initial begin
    forever begin
      @(negedge clk);
      doneAuto = 1'b0;
      if (rst) begin
        pending = 0;
      end else begin
        if (pending > 0) begin
          pending = pending - 1;
          if (pending == 0) doneAuto = 1'b1;
        end
        if (en && doneDelay > 0) pending = doneDelay;
      end
    end
  end

  // Issue monitor: log data_in and cycle of every en strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (en) begin
        issuedQ.push_back(data_in);
        enCycleQ.push_back(cycleNo);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] t,
                               input logic [7:0] w, input logic l);
    s_valid = v;
    s_type  = t;
    s_word  = w;
    s_last  = l;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for s_ready, then present one word for exactly one edge.
  task automatic pushWord(input logic [1:0] t, input logic [7:0] w, input logic l);
    int guard = 0;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      checkOutput("push_ready_wait", 32'(s_ready), 32'd1);
    end else begin
      applyStimulus(1'b1, t, w, l);
      @(negedge clk);
      applyStimulus(1'b0, T_NONE, 8'h00, 1'b0);
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    doneForce = 1'b0;
    applyStimulus(1'b0, T_NONE, 8'h00, 1'b0);
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int startCount;
    logic [9:0] expQ [$];

    doneDelay = 0;
    rst       = 1'b1;
    applyStimulus(1'b0, T_NONE, 8'h00, 1'b0);
    tick(2);

    // Reset state
    checkOutput("rst_data_in",  32'(data_in),      32'h0);
    checkOutput("rst_en",       32'(en),           32'h0);
    checkOutput("rst_we_sen",   32'(we_sen),       32'h0);
    checkOutput("rst_we_query", 32'(we_query),     32'h0);
    checkOutput("rst_story",    32'(story_done),   32'h0);
    checkOutput("rst_sen_cnt",  32'(sen_count),    32'h0);
    checkOutput("rst_ovf",      32'(err_overflow), 32'h0);
    checkOutput("rst_tmo",      32'(err_timeout),  32'h0);
    checkOutput("rst_s_ready",  32'(s_ready),      32'h0);
    rst = 1'b0;
    tick(1);
    checkOutput("post_rst_ready", 32'(s_ready), 32'h1);
    checkOutput("post_rst_en",    32'(en),      32'h0);

    // Two sentences, done_emb two cycles after each en
    $display("[TB] sentence issue and spacing");
    doneDelay = 2;
    base = issuedQ.size();
    pushWord(T_SEN, 8'h12, 1'b0);
    pushWord(T_SEN, 8'h34, 1'b0);
    checkOutput("sen_en",       32'(en),       32'h1);
    checkOutput("sen_we_sen",   32'(we_sen),   32'h1);
    checkOutput("sen_we_query", 32'(we_query), 32'h0);
    checkOutput("sen_data_in",  32'(data_in),  32'h112);
    tick(1);
    checkOutput("sen_en_pulse", 32'(en),        32'h0);
    checkOutput("sen_count_1",  32'(sen_count), 32'h1);
    checkOutput("sen_hold",     32'(data_in),   32'h112);
    tick(12);
    checkOutput("sen_issues", 32'(issuedQ.size() - base), 32'd2);
    if (issuedQ.size() - base == 2) begin
      checkOutput("sen_second_word", 32'(issuedQ[base+1]), 32'h134);
      checkOutput("sen_spacing", 32'(enCycleQ[base+1] - enCycleQ[base]), 32'd5);
    end
    checkOutput("sen_count_2", 32'(sen_count), 32'h2);

    // Answer with last set ends the story
    $display("[TB] answer word ends story");
    pushWord(T_ANS, 8'h07, 1'b1);
    tick(1);
    checkOutput("ans_en",       32'(en),       32'h1);
    checkOutput("ans_data_in",  32'(data_in),  32'h307);
    checkOutput("ans_we_sen",   32'(we_sen),   32'h0);
    checkOutput("ans_we_query", 32'(we_query), 32'h0);
    tick(1);
    checkOutput("ans_story_done", 32'(story_done), 32'h1);
    checkOutput("ans_cnt_held",   32'(sen_count),  32'h2);
    tick(1);
    checkOutput("ans_story_pulse", 32'(story_done), 32'h0);
    checkOutput("ans_cnt_clear",   32'(sen_count),  32'h0);

    // Seventeen sentences: the 17th overflows memory
    $display("[TB] sentence overflow");
    doneDelay = 1;
    base = issuedQ.size();
    for (int i = 0; i < 17; i++) pushWord(T_SEN, 8'h40 + 8'(i), 1'b0);
    tick(50);
    checkOutput("ovf_issues", 32'(issuedQ.size() - base), 32'd16);
    if (issuedQ.size() - base == 16)
      checkOutput("ovf_last_issued", 32'(issuedQ[base+15]), 32'h14F);
    checkOutput("ovf_sen_count", 32'(sen_count),    32'd16);
    checkOutput("ovf_flag",      32'(err_overflow), 32'h1);
    checkOutput("ovf_no_tmo",    32'(err_timeout),  32'h0);

    // Question with done withheld times out, then the next word issues
    $display("[TB] question timeout");
    doneDelay = 0;
    doReset();
    checkOutput("rst2_sen_count", 32'(sen_count),    32'h0);
    checkOutput("rst2_ovf",       32'(err_overflow), 32'h0);
    pushWord(T_QRY, 8'h33, 1'b0);
    pushWord(T_ANS, 8'h55, 1'b0);
    checkOutput("qry_en",       32'(en),       32'h1);
    checkOutput("qry_we_query", 32'(we_query), 32'h1);
    checkOutput("qry_we_sen",   32'(we_sen),   32'h0);
    checkOutput("qry_data_in",  32'(data_in),  32'h233);
    tick(64);
    checkOutput("tmo_not_yet", 32'(err_timeout), 32'h0);
    checkOutput("tmo_hold",    32'(data_in),     32'h233);
    tick(1);
    checkOutput("tmo_set", 32'(err_timeout), 32'h1);
    tick(2);
    checkOutput("tmo_next_en",   32'(en),      32'h1);
    checkOutput("tmo_next_data", 32'(data_in), 32'h355);

    // FIFO fill, back-pressure and scoreboard order
    $display("[TB] fifo full and ordering");
    doReset();
    checkOutput("rst3_tmo", 32'(err_timeout), 32'h0);
    base = issuedQ.size();
    pushWord(T_QRY, 8'h80, 1'b0);
    for (int i = 1; i <= 8; i++) pushWord(T_ANS, 8'h80 + 8'(i), 1'b0);
    checkOutput("full_ready", 32'(s_ready), 32'h0);
    applyStimulus(1'b1, T_ANS, 8'h89, 1'b0);
    tick(1);
    checkOutput("full_hold_ready", 32'(s_ready), 32'h0);
    doneForce = 1'b1;
    tick(1);
    doneForce = 1'b0;
    checkOutput("full_gap_ready", 32'(s_ready), 32'h0);
    tick(1);
    checkOutput("full_idle_ready", 32'(s_ready), 32'h0);
    tick(1);
    checkOutput("full_after_pop", 32'(s_ready), 32'h1);
    tick(1);
    applyStimulus(1'b0, T_NONE, 8'h00, 1'b0);
    pushWord(T_ANS, 8'h8A, 1'b0);
    tick(60);
    expQ = {10'h280};
    for (int i = 1; i <= 10; i++) expQ.push_back({T_ANS, 8'h80 + 8'(i)});
    startCount = issuedQ.size() - base;
    checkOutput("sb_count", 32'(startCount), 32'd11);
    if (startCount == 11) begin
      for (int i = 0; i < 11; i++)
        checkOutput($sformatf("sb_word_%0d", i), 32'(issuedQ[base+i]), 32'(expQ[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/memn2n_story_tx.md
# memn2n_story_tx

Story transmitter for the MemN2N core. It accepts a stream of type-tagged words from the host over a valid/ready handshake and buffers them in a small FIFO. It then presents them one at a time on the core's `data_in` bus as `{type_code, word_vec}` with a one-cycle `en` strobe and the matching `we_sen`/`we_query` qualifiers. After each sentence or question word it waits for the embedding unit's `done` before issuing the next word. It also counts sentences against memory capacity and flags overflow and timeouts.

## Interface
- BW_WORD_VEC, 8, word-vector field width
- BW_TYPE_CODE, 2, type-code field width (00 none, 01 sentence, 10 question, 11 answer)
- BW_DATA_IN, BW_WORD_VEC+BW_TYPE_CODE, `data_in` width
- BW_MEM_ADDR, 4, memory address width; capacity NUM_MEM = 1<<BW_MEM_ADDR sentence words per story
- BW_FIFO_DEPTH, 3, log2 of FIFO depth (8 entries)
- TIMEOUT, 64, max WAIT cycles before giving up on `done_emb`
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  host word valid
- s_ready  out  1  = !fifo_full && !rst
- s_word  in  BW_WORD_VEC  host word vector
- s_type  in  BW_TYPE_CODE  host type code
- s_last  in  1  last word of story
- data_in  out  BW_DATA_IN  {type, word}: type in MSBs, word in LSBs; held between words
- en  out  1  one-cycle issue strobe
- we_sen  out  1  high only in issue cycle of a sentence word
- we_query  out  1  high only in issue cycle of a question word
- done_emb  in  1  embedding-complete pulse from the active embedding unit
- story_done  out  1  one-cycle pulse after the last word of a story completes
- sen_count  out  BW_MEM_ADDR+1  sentence words issued in the current story
- err_overflow  out  1  sticky; a sentence word was dropped because memory was full
- err_timeout  out  1  sticky; WAIT expired without `done_emb`

## Operation
- A push happens when `s_valid && s_ready`. Fields {s_last, s_type, s_word} are written at the tail. A pushed word is not poppable until the next cycle (no bypass).
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE with FIFO non-empty: pop the head into the holding register.
  - type 00: discard, stay in IDLE. If its last flag is set, pulse `story_done` next cycle.
  - sentence with `sen_count == NUM_MEM`: drop it, set `err_overflow`, stay in IDLE. The last flag is handled as for type 00.
  - otherwise go to ISSUE.
- ISSUE: `en`=1, `data_in` = held word, and `we_sen`/`we_query` per type. Sentence increments `sen_count`. Answer goes to GAP; sentence or question goes to WAIT.
- WAIT: the wait counter increments each cycle.
  - `done_emb`=1 → GAP.
  - counter reaches TIMEOUT-1 with no `done_emb` → set `err_timeout`, go to GAP.
  - `done_emb` in the ISSUE cycle itself is ignored.
- GAP: one idle cycle. If the held word had last set, pulse `story_done`, clear `sen_count` (the clear takes effect the cycle after the pulse), then go to IDLE.
- Error flags clear only on `rst`.

## Timing
- Reset values: `data_in`=0, `en`=0, `we_sen`=0, `we_query`=0, `story_done`=0, `sen_count`=0, `err_overflow`=0, `err_timeout`=0, `s_ready`=0 during reset, FIFO empty, FSM in IDLE.
- Latency:
  - push to `en`: minimum 3 cycles (push edge, IDLE pop, ISSUE).
  - answer word: 3 cycles per word (IDLE, ISSUE, GAP).
  - sentence/question word: 3 + k cycles, where `done_emb` arrives k cycles after ISSUE (k ≥ 1).
  - `story_done` is asserted during the GAP cycle of the last word.
- FIFO full: `s_ready`=0; the host must hold its data. A push and a pop in the same cycle are legal at any fill level below full, and the count is unchanged.
- Pointers wrap modulo the depth. Full and empty are distinguished by an extra pointer bit.
- `sen_count` saturates at NUM_MEM and never wraps.
- Reset mid-operation: any state returns to IDLE next cycle, in-flight and buffered words are lost, and no `en` is issued.
- `data_in` changes only on a pop into ISSUE. It is stable for the whole WAIT/GAP window.

## Test plan
- Reset → all outputs 0 and `s_ready`=0. First cycle after reset: `s_ready`=1, FIFO empty, no `en`.
- Push sentence 0x12 (type 01) with `done_emb` 2 cycles after `en` → `data_in`=0x112, `en`+`we_sen` for 1 cycle, `sen_count`=1, next issue no earlier than 5 cycles after the first.
- Push answer 0x07 (last=1) → `data_in`=0x307, `en` without `we_*`, `story_done` 1 cycle after `en`, `sen_count` returns to 0 the following cycle.
- Push 17 sentence words (BW_MEM_ADDR=4) with `done_emb` always returned → 16 `en` strobes, `sen_count`=16, the 17th word is dropped, `err_overflow`=1.
- Push question 0x33 and withhold `done_emb` → `we_query` pulse, `err_timeout` sets after 64 WAIT cycles, FSM returns to IDLE and issues the next buffered word.
- Hold `s_valid` with `done_emb` withheld → FIFO fills to 8, `s_ready`=0. Return `done_emb` → one pop, `s_ready`=1 the next cycle, and no word is lost or duplicated (scoreboard order check).
